// File: rtl/phv_buffer.sv
`default_nettype none
// ============================================================================
// Module   : phv_buffer
// Purpose  : Elastic PHV buffer between the parser and the first match-action
//            stage. Captures single-cycle parser strobes and re-presents them on
//            a valid/ready handshake, preserving order. Storage is a circular
//            array of DEPTH-1 entries plus the output register.
// Options  : PHV_BUF_STATS_EN - when defined, implements drop_cnt and hwm;
//            otherwise both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module phv_buffer #(
  parameter int PKT_HDR_LEN  = 1124,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                   axis_clk,
  input  logic                   aresetn,
  input  logic [PKT_HDR_LEN-1:0] phv_in,
  input  logic                   phv_in_valid,
  output logic [PKT_HDR_LEN-1:0] phv_out,
  output logic                   phv_out_valid,
  input  logic                   phv_out_ready,
  output logic                   buf_almost_full,
  output logic [DEPTH_LOG2:0]    buf_count,
  output logic [31:0]            drop_cnt,
  output logic [DEPTH_LOG2:0]    hwm
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int RAM_DEPTH = DEPTH - 1;
  localparam int CNT_W     = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0]      C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      C_AFULL    = CNT_W'(AFULL_THRESH);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_LAST = DEPTH_LOG2'(RAM_DEPTH - 1);
  localparam logic [DEPTH_LOG2-1:0] C_ONE      = DEPTH_LOG2'(1);

  logic [PKT_HDR_LEN-1:0] mem_q [RAM_DEPTH];

  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0]  ram_cnt_q, ram_cnt_d;
  logic [PKT_HDR_LEN-1:0] phv_out_q, phv_out_d;
  logic                   out_valid_q, out_valid_d;

  logic [CNT_W-1:0]       count;
  logic                   pop, full, wr_acc, bypass, reload, ram_wr, ram_rd;

  // Handshake decode, output reload selection and pointer/occupancy next state
  always_comb begin
    count  = {1'b0, ram_cnt_q} + {{DEPTH_LOG2{1'b0}}, out_valid_q};
    pop    = out_valid_q & phv_out_ready;
    // Acceptance looks only at registered occupancy: a pop in the same cycle
    // does not rescue a strobe arriving while full.
    full   = (count == C_DEPTH);
    wr_acc = phv_in_valid & ~full;
    bypass = (ram_cnt_q == '0) & (~out_valid_q | pop);
    reload = pop | ~out_valid_q;
    ram_rd = reload & (ram_cnt_q != '0);
    ram_wr = wr_acc & ~bypass;

    phv_out_d   = phv_out_q;
    out_valid_d = out_valid_q;
    if (reload) begin
      if (ram_rd) begin
        phv_out_d   = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
      end else if (wr_acc) begin
        phv_out_d   = phv_in;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    rd_ptr_d = rd_ptr_q;
    if (ram_rd) rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + C_ONE;

    wr_ptr_d = wr_ptr_q;
    if (ram_wr) wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + C_ONE;

    unique case ({ram_wr, ram_rd})
      2'b10:   ram_cnt_d = ram_cnt_q + C_ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - C_ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  // Control state and output register; reset discards every held PHV
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      phv_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      phv_out_q   <= phv_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array write; contents need no reset since pointers gate reads
  always_ff @(posedge axis_clk) begin
    if (ram_wr) mem_q[wr_ptr_q] <= phv_in;
  end

  assign phv_out         = phv_out_q;
  assign phv_out_valid   = out_valid_q;
  assign buf_count       = count;
  assign buf_almost_full = (count >= C_AFULL);

`ifdef PHV_BUF_STATS_EN
  logic [31:0]      drop_cnt_q;
  logic [CNT_W-1:0] hwm_q;
  logic [CNT_W-1:0] count_d;

  // Next-edge occupancy so hwm becomes visible in the same cycle as buf_count
  always_comb begin
    unique case ({wr_acc, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Saturating drop counter and occupancy high-water mark
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      if (phv_in_valid && full && (drop_cnt_q != 32'hFFFF_FFFF))
        drop_cnt_q <= drop_cnt_q + 32'd1;
      if (count_d > hwm_q)
        hwm_q <= count_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign hwm      = hwm_q;
`else
  assign drop_cnt = '0;
  assign hwm      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phv_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phv_buffer
// Purpose  : Scoreboard bench for phv_buffer. A negedge monitor keeps an
//            occupancy/statistics model, pushes accepted PHVs and compares
//            every pop in order; scenario tasks add targeted inline checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phv_buffer;
  localparam int W     = 1124;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          axis_clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [W-1:0]  phv_in = '0;
  logic          phv_in_valid = 1'b0;
  logic          phv_out_ready = 1'b0;
  logic [W-1:0]  phv_out;
  logic          phv_out_valid;
  logic          buf_almost_full;
  logic [DL:0]   buf_count;
  logic [31:0]   drop_cnt;
  logic [DL:0]   hwm;

  phv_buffer #(.PKT_HDR_LEN(W), .DEPTH_LOG2(DL), .AFULL_THRESH(12)) dut (
    .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in),
    .phv_in_valid(phv_in_valid), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready), .buf_almost_full(buf_almost_full),
    .buf_count(buf_count), .drop_cnt(drop_cnt), .hwm(hwm)
  );

  always #5 axis_clk = ~axis_clk;

  int vectors = 0;
  int errors  = 0;

`ifdef PHV_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Scoreboard / model state
  logic [W-1:0] sb[$];
  int           m_cnt = 0;
  int           m_drop = 0;
  int           m_hwm = 0;
  bit           mon_en = 1'b0;
  bit           hold_pending = 1'b0;
  logic [W-1:0] hold_val;

  // Monitor: sampled on the falling edge, ahead of the rising edge it models
  always @(negedge axis_clk) begin
    logic [W-1:0] exp_v;
    bit acc, pop;
    int e_drop, e_hwm;
    if (mon_en) begin
      e_drop = STATS ? m_drop : 0;
      e_hwm  = STATS ? m_hwm  : 0;
      vectors++;
      if (buf_count !== 5'(m_cnt)) begin
        errors++; $display("FAIL mon_count: got %0d exp %0d", buf_count, m_cnt);
      end
      vectors++;
      if (phv_out_valid !== (m_cnt != 0)) begin
        errors++; $display("FAIL mon_valid: got %0b exp %0b", phv_out_valid, m_cnt != 0);
      end
      vectors++;
      if (drop_cnt !== 32'(e_drop) || hwm !== 5'(e_hwm)) begin
        errors++; $display("FAIL mon_stats: got drop %0d hwm %0d exp drop %0d hwm %0d",
                           drop_cnt, hwm, e_drop, e_hwm);
      end
      if (hold_pending) begin
        vectors++;
        if (phv_out !== hold_val) begin
          errors++; $display("FAIL mon_hold: got %h exp %h", phv_out[63:0], hold_val[63:0]);
        end
      end
      hold_pending = aresetn && phv_out_valid && !phv_out_ready;
      hold_val     = phv_out;
      if (!aresetn) begin
        sb.delete();
        m_cnt = 0; m_drop = 0; m_hwm = 0;
      end else begin
        acc = phv_in_valid && (m_cnt < DEPTH);
        pop = phv_out_ready && (m_cnt > 0);
        if (phv_in_valid && !acc) m_drop++;
        if (acc) sb.push_back(phv_in);
        if (pop) begin
          vectors++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL mon_pop_empty: got pop exp none");
          end else begin
            exp_v = sb.pop_front();
            if (phv_out !== exp_v) begin
              errors++; $display("FAIL mon_order: got %h exp %h", phv_out[63:0], exp_v[63:0]);
            end
          end
        end
        m_cnt = m_cnt + int'(acc) - int'(pop);
        if (m_cnt > m_hwm) m_hwm = m_cnt;
      end
    end
  end

  task automatic cyc();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) cyc();
    vectors++;
    if (phv_out !== '0 || phv_out_valid !== 1'b0 || buf_count !== '0 ||
        buf_almost_full !== 1'b0 || drop_cnt !== '0 || hwm !== '0) begin
      errors++; $display("FAIL reset_values: got valid %0b count %0d af %0b drop %0d hwm %0d exp all 0",
                         phv_out_valid, buf_count, buf_almost_full, drop_cnt, hwm);
    end
    aresetn = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_single();
    phv_in = W'(32'hA5); phv_in_valid = 1'b1; phv_out_ready = 1'b1;
    cyc();
    phv_in_valid = 1'b0;
    vectors++;
    if (phv_out_valid !== 1'b1 || phv_out !== W'(32'hA5)) begin
      errors++; $display("FAIL single_latency: got valid %0b data %h exp 1 a5", phv_out_valid, phv_out[63:0]);
    end
    cyc();
    vectors++;
    if (buf_count !== '0) begin
      errors++; $display("FAIL single_drain: got %0d exp 0", buf_count);
    end
    phv_out_ready = 1'b0;
  endtask

  task automatic test_fill(input int base, input int n);
    phv_out_ready = 1'b0;
    for (int i = 1; i <= n; i++) begin
      phv_in = W'(base + i); phv_in_valid = 1'b1;
      cyc();
      vectors++;
      if (buf_count !== 5'(i) || buf_almost_full !== (i >= 12)) begin
        errors++; $display("FAIL fill_%0d: got count %0d af %0b exp %0d %0b",
                           i, buf_count, buf_almost_full, i, i >= 12);
      end
    end
    phv_in_valid = 1'b0;
  endtask

  task automatic test_overflow();
    phv_in = W'(999); phv_in_valid = 1'b1;
    cyc();
    phv_in_valid = 1'b0;
    vectors++;
    if (buf_count !== 5'd16 || drop_cnt !== (STATS ? 32'd1 : 32'd0) || hwm !== (STATS ? 5'd16 : 5'd0)) begin
      errors++; $display("FAIL overflow: got count %0d drop %0d hwm %0d exp 16 %0d %0d",
                         buf_count, drop_cnt, hwm, STATS ? 1 : 0, STATS ? 16 : 0);
    end
  endtask

  task automatic test_drain(input int n);
    phv_out_ready = 1'b1;
    repeat (n) cyc();
    vectors++;
    if (phv_out_valid !== 1'b0 || buf_count !== '0) begin
      errors++; $display("FAIL drain_end: got valid %0b count %0d exp 0 0", phv_out_valid, buf_count);
    end
    phv_out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    test_fill(100, 16);
    phv_in = W'(555); phv_in_valid = 1'b1; phv_out_ready = 1'b1;
    vectors++;
    if (phv_out !== W'(101)) begin
      errors++; $display("FAIL full_pop_head: got %0d exp 101", phv_out[31:0]);
    end
    cyc();
    phv_in_valid = 1'b0; phv_out_ready = 1'b0;
    vectors++;
    if (buf_count !== 5'd15 || drop_cnt !== (STATS ? 32'd2 : 32'd0)) begin
      errors++; $display("FAIL full_pop: got count %0d drop %0d exp 15 %0d",
                         buf_count, drop_cnt, STATS ? 2 : 0);
    end
    test_drain(15);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 40; i++) begin
      phv_in = W'(1000 + i); phv_in_valid = 1'b1; phv_out_ready = (i % 2 == 0);
      cyc();
      if (i == 29) begin
        vectors++;
        if (drop_cnt !== (STATS ? 32'd2 : 32'd0) || buf_count !== 5'd16) begin
          errors++; $display("FAIL stream_nodrop: got drop %0d count %0d exp %0d 16",
                             drop_cnt, buf_count, STATS ? 2 : 0);
        end
      end
    end
    phv_in_valid = 1'b0;
    vectors++;
    if (drop_cnt !== (STATS ? 32'd7 : 32'd0) || hwm !== (STATS ? 5'd16 : 5'd0)) begin
      errors++; $display("FAIL stream_stats: got drop %0d hwm %0d exp %0d %0d",
                         drop_cnt, hwm, STATS ? 7 : 0, STATS ? 16 : 0);
    end
    test_drain(16);
  endtask

  task automatic test_reset_mid();
    test_fill(200, 9);
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    vectors++;
    if (phv_out !== '0 || phv_out_valid !== 1'b0 || buf_count !== '0 ||
        buf_almost_full !== 1'b0 || drop_cnt !== '0 || hwm !== '0) begin
      errors++; $display("FAIL reset_mid: got valid %0b count %0d drop %0d hwm %0d exp all 0",
                         phv_out_valid, buf_count, drop_cnt, hwm);
    end
    phv_in = W'(7); phv_in_valid = 1'b1; phv_out_ready = 1'b1;
    cyc();
    phv_in_valid = 1'b0;
    vectors++;
    if (phv_out_valid !== 1'b1 || phv_out !== W'(7)) begin
      errors++; $display("FAIL reset_mid_first: got valid %0b data %0d exp 1 7", phv_out_valid, phv_out[31:0]);
    end
    cyc();
    phv_out_ready = 1'b0;
  endtask

  initial begin
    @(posedge axis_clk);
    #1;
    test_reset();
    test_single();
    test_fill(0, 16);
    test_overflow();
    test_drain(16);
    test_full_pop();
    test_stream();
    test_reset_mid();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phv_buffer.md
# phv_buffer

Elastic buffer between the parser and the first match-action stage. It captures every packet header vector (PHV) the parser emits as a single-cycle `parser_valid` pulse and re-presents it on a valid/ready handshake, so downstream stages can stall without losing PHVs. It drives an almost-full indication back toward ingress for throttling, and counts PHVs dropped on overflow. PHV order is strictly preserved.

## Interface
Parameters:
- `PKT_HDR_LEN`, 1124: PHV width in bits; must match the parser output.
- `DEPTH_LOG2`, 4: total capacity `DEPTH` = 2^DEPTH_LOG2 PHVs, counting storage plus the output register.
- `AFULL_THRESH`, 12: occupancy at or above which `buf_almost_full` asserts; legal range 1..DEPTH.

Ports:
- `axis_clk`  in  1  clock; all logic is on its rising edge.
- `aresetn`  in  1  synchronous, active-low reset.
- `phv_in`  in  PKT_HDR_LEN  PHV from the parser (`pkt_hdr_vec`).
- `phv_in_valid`  in  1  one-cycle strobe (`parser_valid`); there is no backpressure on this side.
- `phv_out`  out  PKT_HDR_LEN  head PHV.
- `phv_out_valid`  out  1  `phv_out` holds a valid PHV.
- `phv_out_ready`  in  1  downstream accepts; a pop occurs when `phv_out_valid && phv_out_ready`.
- `buf_almost_full`  out  1  asserted when occupancy >= AFULL_THRESH.
- `buf_count`  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- `drop_cnt`  out  32  PHVs dropped since reset; saturates.
- `hwm`  out  DEPTH_LOG2+1  maximum occupancy observed since reset.

## Operation
- Storage:
  - Circular array of DEPTH-1 entries with combinational read, plus the output register (`phv_out` / `phv_out_valid`).
  - `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits and wrap modulo DEPTH-1.
  - A separate `ram_cnt` tracks array occupancy.
- Occupancy: `buf_count` = ram_cnt + phv_out_valid, updated each edge by (+1 on accepted write) and (−1 on pop).
- Write acceptance:
  - Uses the registered `buf_count` only.
  - `phv_in_valid` with `buf_count == DEPTH` is dropped, even if a pop occurs in the same cycle.
  - A drop increments `drop_cnt`.
- Write routing:
  - Bypass to the output register when ram_cnt==0 and (phv_out_valid==0 or pop this cycle).
  - Otherwise the PHV is written to the array at `wr_ptr`.
- Output reload on pop, or when phv_out_valid==0:
  - If ram_cnt>0, load array[rd_ptr] and advance rd_ptr.
  - Else if bypass applies, load `phv_in`.
  - Else clear `phv_out_valid`.
- Simultaneous write and pop with ram_cnt>0: the head is reloaded from the array, the new PHV goes to the array, and occupancy is unchanged.
- Hold rule: while `phv_out_valid && !phv_out_ready`, `phv_out` is stable.
- `hwm` updates to `buf_count` whenever `buf_count > hwm`.
- `drop_cnt` saturates at 32'hFFFF_FFFF.

## Timing
- Reset values: `phv_out`=0, `phv_out_valid`=0, `buf_count`=0, `buf_almost_full`=0, `drop_cnt`=0, `hwm`=0; wr_ptr, rd_ptr and ram_cnt are 0.
- Reset mid-operation discards all held PHVs and clears all counters on that edge.
- Latency, empty buffer: strobe in cycle N gives `phv_out_valid`=1 with that PHV in cycle N+1.
- Throughput: one pop per cycle sustained while occupancy > 0, with no bubbles.
- `buf_count` and `hwm` reflect the edge at which the write or pop occurred, i.e. visible in the next cycle.
- `buf_almost_full` is a combinational compare of registered `buf_count`, so it is a registered-timing signal.
- Ingress throttling must tolerate the parser's in-flight PHVs (up to 4 cycles of FSM latency).

## Configuration
- Macro `PHV_BUF_STATS_EN`.
- Defined: `drop_cnt` and `hwm` are implemented as described.
- Undefined:
  - `drop_cnt` and `hwm` are tied to constant 0 and their registers are not instantiated.
  - Drop behaviour, `buf_count` and `buf_almost_full` are unchanged.

## Test plan
- Single PHV, empty buffer: phv_in=1124'hA5 strobe in cycle 0, ready=1 → phv_out_valid=1 with phv_out=1124'hA5 in cycle 1; buf_count returns to 0 after the pop.
- Fill with ready=0 (defaults): write 16 PHVs with values 1..16 → buf_count=16; buf_almost_full rises when buf_count reaches 12; 17th strobe is dropped, drop_cnt=1, hwm=16.
- Drain after fill: ready=1 → phv_out carries 1..16 in order on 16 consecutive cycles, then phv_out_valid=0 and buf_count=0.
- Full with simultaneous strobe and pop (buf_count=16): the strobe is dropped (drop_cnt+1), buf_count=15 next cycle, and the popped value is the oldest PHV.
- Steady stream: strobe every cycle with ready toggling 1,0,1,0 for 40 cycles → no drops before occupancy reaches 16, order preserved, phv_out stable during every ready=0 cycle. Repeat with `PHV_BUF_STATS_EN` undefined → drop_cnt=0 and hwm=0 throughout.
- Reset mid-fill: aresetn=0 for 1 cycle with buf_count=9 → all outputs at reset values next cycle; subsequent PHV 1124'h7 appears as the first output.
